// File: rtl/shift_pkg.sv
// Shared shifter encodings: operation codes and control-FSM states.
// The ALU decoder imports the same op encodings.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_e;

endpackage

// File: rtl/shift_unit_if.sv
// Request/result handshake bundle for shift_unit.
// The master side issues requests and consumes results; the slave side is the unit.
interface shift_unit_if #(
    parameter int WIDTH = 32
) ();
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   shamt;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;

    modport master (
        output in_valid, a, shamt, op, out_ready,
        input  in_ready, out_valid, y, zero
    );

    modport slave (
        input  in_valid, a, shamt, op, out_ready,
        output in_ready, out_valid, y, zero
    );
endinterface

// File: rtl/shift_step.sv
// Combinational single-cycle shifter: shifts data by k (0..STEP) bits
// according to op.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0]           data_i,
    input  logic [$clog2(STEP+1)-1:0]  k_i,
    input  shift_op_e                  op_i,
    output logic [WIDTH-1:0]           data_o
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] WFULL = (SHW+1)'(WIDTH);

    // Right-shift distance for the rotate's wrap-around part; k=0 gives WIDTH,
    // which shifts everything out and leaves data unchanged.
    logic [SHW:0] rk;

    always_comb begin
        rk     = WFULL - (SHW+1)'(k_i);
        data_o = data_i;
        case (op_i)
            OP_SLL:  data_o = data_i << k_i;
            OP_SRL:  data_o = data_i >> k_i;
            OP_SRA:  data_o = $signed(data_i) >>> k_i;
            OP_ROL:  data_o = (data_i << k_i) | (data_i >> rk);
            default: data_o = data_i;
        endcase
    end
endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shifter: captures a request, shifts up to STEP bits per cycle,
// then holds the result until the consumer takes it.
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic         clk,
    input  logic         rst,
    shift_unit_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int KW  = $clog2(STEP+1);

    shift_state_e     state_q;
    shift_op_e        op_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_d;
    logic [SHW-1:0]   rem_q;
    logic [SHW-1:0]   rem_d;
    logic [KW-1:0]    k;
    logic             in_ready_q;
    logic             out_valid_q;

    // Per-cycle amount is min(STEP, remaining).
    always_comb begin
        k = KW'(rem_q);
        if (32'(rem_q) >= STEP) begin
            k = KW'(STEP);
        end
        rem_d = rem_q - SHW'(k);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data_i (work_q),
        .k_i    (k),
        .op_i   (op_q),
        .data_o (work_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_SLL;
            work_q      <= '0;
            rem_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        work_q     <= bus.a;
                        rem_q      <= bus.shamt;
                        op_q       <= shift_op_e'(bus.op);
                        in_ready_q <= 1'b0;
                        if (bus.shamt == '0) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    work_q <= work_d;
                    rem_q  <= rem_d;
                    if (rem_d == '0) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Release goes back to IDLE only; a new request waits for the next edge.
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = work_q;
    assign bus.zero      = (work_q == '0);
endmodule

// File: tb/tb_shift_unit.sv
// Bench for shift_unit: a STEP=1 and a STEP=4 instance receive the same requests
// and are compared against a bit-position reference model.
module tb_shift_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [1:0]  op;

    int checks;
    int errors;

    shift_unit_if #(.WIDTH(32)) b1 ();
    shift_unit_if #(.WIDTH(32)) b4 ();

    assign b1.in_valid  = in_valid;
    assign b1.out_ready = out_ready;
    assign b1.a         = a;
    assign b1.shamt     = shamt;
    assign b1.op        = op;
    assign b4.in_valid  = in_valid;
    assign b4.out_ready = out_ready;
    assign b4.a         = a;
    assign b4.shamt     = shamt;
    assign b4.op        = op;

    shift_unit #(.WIDTH(32), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    shift_unit #(.WIDTH(32), .STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result bit i comes from operand bit i+sh (right), i-sh (left) or wraps (rotate).
    function automatic logic [31:0] ref_shift(input logic [31:0] av, input int sh, input int opv);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            case (opv)
                0: if (i >= sh) r[i] = av[i-sh];
                1: if (i + sh < 32) r[i] = av[i+sh];
                2: r[i] = (i + sh < 32) ? av[i+sh] : av[31];
                default: r[(i+sh) % 32] = av[i];
            endcase
        end
        return r;
    endfunction

    function automatic int exp_lat(input int sh, input int step);
        return 1 + (sh + step - 1) / step;
    endfunction

    // Issues one request to both units and records each unit's out_valid latency
    // (0 if it never appears within the budget).
    task automatic run_req(input logic [31:0] av, input logic [4:0] sh, input logic [1:0] opv,
                           output int lat1, output int lat4);
        a = av; shamt = sh; op = opv; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; shamt = 5'($urandom); op = 2'($urandom);
        lat1 = 0; lat4 = 0;
        for (int n = 1; n <= 100; n++) begin
            if (lat1 == 0 && b1.out_valid === 1'b1) lat1 = n;
            if (lat4 == 0 && b4.out_valid === 1'b1) lat4 = n;
            if (lat1 != 0 && lat4 != 0) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int l1, l4;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; shamt = '0; op = '0;
        #1;
        checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready1 got %b exp 1", b1.in_ready); end
        checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid1 got %b exp 0", b1.out_valid); end
        checks++; if (b1.y !== 32'h0) begin errors++; $display("FAIL reset_y1 got %h exp 0", b1.y); end
        checks++; if (b1.zero !== 1'b1) begin errors++; $display("FAIL reset_zero1 got %b exp 1", b1.zero); end
        checks++; if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0 || b4.y !== 32'h0 || b4.zero !== 1'b1)
            begin errors++; $display("FAIL reset_dut4 got rdy=%b vld=%b y=%h z=%b exp 1 0 0 1", b4.in_ready, b4.out_valid, b4.y, b4.zero); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_req(32'h12345678, 5'd0, 2'b00, l1, l4);
        checks++; if (b1.y !== 32'h12345678 || l1 !== 1) begin errors++; $display("FAIL first_accept1 got y=%h lat=%0d exp 12345678 lat=1", b1.y, l1); end
        checks++; if (b4.y !== 32'h12345678 || l4 !== 1) begin errors++; $display("FAIL first_accept4 got y=%h lat=%0d exp 12345678 lat=1", b4.y, l4); end
        release_result();
    endtask

    logic [31:0] d_a   [6] = '{32'h00000001, 32'h80000000, 32'h80000000, 32'h80000001, 32'h00000000, 32'hF0000000};
    logic [4:0]  d_sh  [6] = '{5'd4, 5'd31, 5'd31, 5'd1, 5'd0, 5'd6};
    logic [1:0]  d_op  [6] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b01};
    logic [31:0] d_exp [6] = '{32'h00000010, 32'hFFFFFFFF, 32'h00000001, 32'h00000003, 32'h00000000, 32'h03C00000};
    int          d_l1  [6] = '{5, 32, 32, 2, 1, 7};
    int          d_l4  [6] = '{2, 9, 9, 2, 1, 3};

    task automatic test_directed();
        int l1, l4;
        for (int i = 0; i < 6; i++) begin
            run_req(d_a[i], d_sh[i], d_op[i], l1, l4);
            checks++; if (b1.y !== d_exp[i]) begin errors++; $display("FAIL dir_y1 case %0d got %h exp %h", i, b1.y, d_exp[i]); end
            checks++; if (b4.y !== d_exp[i]) begin errors++; $display("FAIL dir_y4 case %0d got %h exp %h", i, b4.y, d_exp[i]); end
            checks++; if (l1 !== d_l1[i]) begin errors++; $display("FAIL dir_lat1 case %0d got %0d exp %0d", i, l1, d_l1[i]); end
            checks++; if (l4 !== d_l4[i]) begin errors++; $display("FAIL dir_lat4 case %0d got %0d exp %0d", i, l4, d_l4[i]); end
            checks++; if (b1.zero !== (d_exp[i] == 32'h0) || b4.zero !== (d_exp[i] == 32'h0))
                begin errors++; $display("FAIL dir_zero case %0d got %b/%b exp %b", i, b1.zero, b4.zero, d_exp[i] == 32'h0); end
            release_result();
        end
    endtask

    task automatic test_hold();
        int l1, l4;
        run_req(32'h00000001, 5'd4, 2'b00, l1, l4);
        for (int c = 0; c < 3; c++) begin
            a = $urandom; shamt = 5'($urandom); op = 2'($urandom); in_valid = ~in_valid;
            @(posedge clk); #1;
            checks++; if (b1.y !== 32'h10 || b4.y !== 32'h10) begin errors++; $display("FAIL hold_y cyc %0d got %h/%h exp 00000010", c, b1.y, b4.y); end
            checks++; if (b1.in_ready !== 1'b0 || b4.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc %0d got %b/%b exp 0", c, b1.in_ready, b4.in_ready); end
            checks++; if (b1.out_valid !== 1'b1 || b4.out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid cyc %0d got %b/%b exp 1", c, b1.out_valid, b4.out_valid); end
        end
        in_valid = 1'b1; a = 32'h5; shamt = 5'd0; op = 2'b00; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (b1.in_ready !== 1'b1 || b4.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b/%b exp 1", b1.in_ready, b4.in_ready); end
        checks++; if (b1.out_valid !== 1'b0 || b4.out_valid !== 1'b0) begin errors++; $display("FAIL release_no_overlap got %b/%b exp 0", b1.out_valid, b4.out_valid); end
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (b1.out_valid !== 1'b1 || b1.y !== 32'h5) begin errors++; $display("FAIL back_to_back1 got vld=%b y=%h exp 1 00000005", b1.out_valid, b1.y); end
        checks++; if (b4.out_valid !== 1'b1 || b4.y !== 32'h5) begin errors++; $display("FAIL back_to_back4 got vld=%b y=%h exp 1 00000005", b4.out_valid, b4.y); end
        release_result();
    endtask

    task automatic test_reset_mid_shift();
        int l1, l4;
        logic [31:0] av;
        a = $urandom | 32'h1; shamt = 5'd20; op = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++; if (b1.in_ready !== 1'b1 || b4.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b/%b exp 1", b1.in_ready, b4.in_ready); end
        checks++; if (b1.out_valid !== 1'b0 || b4.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b/%b exp 0", b1.out_valid, b4.out_valid); end
        checks++; if (b1.y !== 32'h0 || b4.y !== 32'h0 || b1.zero !== 1'b1) begin errors++; $display("FAIL midrst_y got %h/%h z=%b exp 0 z=1", b1.y, b4.y, b1.zero); end
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (b1.out_valid !== 1'b0 || b4.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_hold_valid got %b/%b exp 0", b1.out_valid, b4.out_valid); end
        end
        rst = 1'b0;
        av = $urandom;
        run_req(av, 5'd13, 2'b10, l1, l4);
        checks++; if (b1.y !== ref_shift(av, 13, 2) || b4.y !== ref_shift(av, 13, 2))
            begin errors++; $display("FAIL after_rst_y got %h/%h exp %h", b1.y, b4.y, ref_shift(av, 13, 2)); end
        checks++; if (l1 !== exp_lat(13, 1) || l4 !== exp_lat(13, 4))
            begin errors++; $display("FAIL after_rst_lat got %0d/%0d exp %0d/%0d", l1, l4, exp_lat(13, 1), exp_lat(13, 4)); end
        release_result();
    endtask

    task automatic test_random();
        int l1, l4, sh, opv;
        logic [31:0] av, ex;
        for (int i = 0; i < 40; i++) begin
            av  = (i % 8 == 0) ? 32'h0 : $urandom;
            sh  = $urandom_range(0, 31);
            opv = $urandom_range(0, 3);
            ex  = ref_shift(av, sh, opv);
            run_req(av, 5'(sh), 2'(opv), l1, l4);
            checks++; if (b1.y !== ex) begin errors++; $display("FAIL rnd_y1 it %0d op %0d sh %0d got %h exp %h", i, opv, sh, b1.y, ex); end
            checks++; if (b4.y !== ex) begin errors++; $display("FAIL rnd_y4 it %0d op %0d sh %0d got %h exp %h", i, opv, sh, b4.y, ex); end
            checks++; if (l1 !== exp_lat(sh, 1) || l4 !== exp_lat(sh, 4))
                begin errors++; $display("FAIL rnd_lat it %0d got %0d/%0d exp %0d/%0d", i, l1, l4, exp_lat(sh, 1), exp_lat(sh, 4)); end
            checks++; if (b1.zero !== (ex == 32'h0)) begin errors++; $display("FAIL rnd_zero it %0d got %b exp %b", i, b1.zero, ex == 32'h0); end
            repeat ($urandom_range(0, 3)) begin
                a = $urandom; in_valid = 1'($urandom);
                @(posedge clk); #1;
                checks++; if (b1.y !== ex || b4.y !== ex) begin errors++; $display("FAIL rnd_hold it %0d got %h/%h exp %h", i, b1.y, b4.y, ex); end
            end
            in_valid = 1'b0;
            release_result();
            checks++; if (b1.in_ready !== 1'b1 || b4.in_ready !== 1'b1) begin errors++; $display("FAIL rnd_idle it %0d got %b/%b exp 1", i, b1.in_ready, b4.in_ready); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid_shift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; power of two, at least 8.
REQ-002 Parameter STEP, default 1, maximum bits shifted per cycle; power of two, at most WIDTH.
REQ-003 Derived constant SHW = clog2(WIDTH), the shift-amount width.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  unit can accept a request.
REQ-008 a  input  WIDTH  operand.
REQ-009 shamt  input  SHW  shift amount, 0..WIDTH-1.
REQ-010 op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 y  output  WIDTH  result.
REQ-014 zero  output  1  high when y equals 0, qualified by out_valid.

Function
REQ-015 The unit SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1, capturing a, shamt and op into internal registers.
REQ-018 On accept, the next state SHALL be DONE if shamt=0, else SHIFT.
REQ-019 Each SHIFT cycle SHALL shift the working register by k = min(STEP, remaining) according to the captured op and decrement remaining by k.
REQ-020 On the SHIFT edge where remaining becomes 0, the next state SHALL be DONE.
REQ-021 out_valid SHALL rise 1 + ceil(shamt/STEP) cycles after the accept edge (1 cycle when shamt=0).
REQ-022 SLL and SRL SHALL fill vacated bits with 0.
REQ-023 SRA SHALL fill vacated bits with the captured operand's MSB.
REQ-024 ROL SHALL rotate left, reinserting bits shifted out of the MSB at the LSB.
REQ-025 The result SHALL be bit-exact with the single-step operation by shamt modulo WIDTH.
REQ-026 In DONE, y and zero SHALL hold stable while out_ready=0, for an unbounded number of cycles.
REQ-027 The edge with out_valid=1 and out_ready=1 SHALL return the FSM to IDLE; no new request is accepted on that same edge (no overlap).
REQ-028 Inputs a, shamt and op SHALL be ignored outside the accept edge; changes during SHIFT or DONE have no effect.
REQ-029 y SHALL present the working register in every state.

Reset
REQ-030 Asserting rst SHALL immediately force IDLE and clear the working register and remaining count to 0, giving in_ready=1, out_valid=0, y=0 and zero=1.
REQ-031 Reset asserted during SHIFT or DONE SHALL discard the in-flight request without emitting out_valid.
REQ-032 The first accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-033 The op encodings SLL/SRL/SRA/ROL and the state encodings SHALL live in the shared package shift_pkg, which is also used by the ALU decoder.
REQ-034 One combinational sub-module, shift_step (inputs: data, k in 0..STEP, op; output: shifted data), SHALL perform the per-cycle shift; shift_unit holds the FSM, counter and registers.
REQ-035 No combinational path SHALL exist from the input ports to y or out_valid.

Verification
REQ-036 WIDTH=32, STEP=1: SLL a=0x00000001, shamt=4 -> y=0x00000010 with out_valid exactly 5 cycles after accept.
REQ-037 SRA a=0x80000000, shamt=31 -> y=0xFFFFFFFF after 32 cycles; SRL with the same inputs -> y=0x00000001.
REQ-038 ROL a=0x80000001, shamt=1 -> y=0x00000003; shamt=0 with a=0 -> y=0, zero=1, latency 1.
REQ-039 Hold out_ready=0 for 3 cycles in DONE while toggling a and in_valid -> y stable, in_ready=0, no second accept; the release edge returns to IDLE.
REQ-040 STEP=4 instance: SRL a=0xF0000000, shamt=6 -> y=0x03C00000 after 3 cycles (shift steps of 4 then 2).
REQ-041 Assert rst mid-SHIFT (SLL, shamt=20, cycle 5) -> same cycle in_ready=1, out_valid=0, y=0; the next request completes normally.
